approx_mul_err_accum: RTL and testbench

Error-metric accumulator that sits directly downstream of the unsigned 8x8 approximate multipliers. It takes a stream of operand pairs with the approximate product each multiplier produced, recomputes the exact product internally, and accumulates characterisation statistics over a programmed number of samples:
- error count
- sum of error distance
- maximum error distance

Results are used to score multiplier variants in hardware-in-the-loop runs.

---
 rtl/approx_mul_err_accum_if.sv | 14 +
 rtl/approx_mul_err_accum.sv | 114 +++++++++++
 tb/tb_approx_mul_err_accum.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_err_accum_if.sv
// approx_mul_err_accum_if: sample stream from the multiplier under test
// (operands plus approximate product) with a valid/ready handshake.
interface approx_mul_err_accum_if #(
   parameter int W = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   x;
   logic [W-1:0]   y;
   logic [2*W-1:0] z;

   modport master (output in_valid, x, y, z, input in_ready);
   modport slave  (input in_valid, x, y, z, output in_ready);
endinterface

// File: rtl/approx_mul_err_accum.sv
// approx_mul_err_accum: recomputes x*y, compares with the approximate product z
// and accumulates error count, error-distance sum and maximum over a programmed run.
module approx_mul_err_accum #(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int SUM_W = 2*W+CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [CNT_W-1:0]     num_samples_i,
   approx_mul_err_accum_if.slave s_if,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_W:0]       sample_count_o,
   output logic [CNT_W:0]       err_count_o,
   output logic [SUM_W-1:0]     ed_sum_o,
   output logic [2*W-1:0]       ed_max_o
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state_q;
   logic             in_ready_q, busy_q, done_q, drain_q;
   logic [CNT_W:0]   target_q, cnt_q, cnt_d, err_q;
   logic [SUM_W-1:0] sum_q;
   logic [2*W-1:0]   max_q, s1_exact_q, s1_z_q, s2_ed_q, ed_d;
   logic             s1_v_q, s2_v_q, s2_err_q;
   logic             accept, start_clr;

   assign accept    = s_if.in_valid && in_ready_q;
   assign start_clr = start_i && (state_q == IDLE || state_q == DONE);
   assign cnt_d     = cnt_q + (CNT_W+1)'(1);
   assign ed_d      = (s1_exact_q >= s1_z_q) ? s1_exact_q - s1_z_q : s1_z_q - s1_exact_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         drain_q    <= 1'b0;
         target_q   <= '0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: if (start_i) begin
               state_q    <= RUN;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b1;
               done_q     <= 1'b0;
               // a zero count selects the full 2^CNT_W run length
               target_q   <= {num_samples_i == '0, num_samples_i};
               cnt_q      <= '0;
            end
            RUN: if (accept) begin
               cnt_q <= cnt_d;
               if (cnt_d == target_q) begin
                  state_q    <= DRAIN;
                  in_ready_q <= 1'b0;
                  drain_q    <= 1'b0;
               end
            end
            DRAIN: begin
               drain_q <= 1'b1;
               if (drain_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q     <= 1'b0;
         s1_exact_q <= '0;
         s1_z_q     <= '0;
         s2_v_q     <= 1'b0;
         s2_ed_q    <= '0;
         s2_err_q   <= 1'b0;
         err_q      <= '0;
         sum_q      <= '0;
         max_q      <= '0;
      end else begin
         s1_v_q     <= accept;
         s1_exact_q <= {{W{1'b0}}, s_if.x} * {{W{1'b0}}, s_if.y};
         s1_z_q     <= s_if.z;
         s2_v_q     <= s1_v_q;
         s2_ed_q    <= ed_d;
         s2_err_q   <= ed_d != '0;
         // the pipeline is empty whenever start is honoured, so clear never races an update
         if (start_clr) begin
            err_q <= '0;
            sum_q <= '0;
            max_q <= '0;
         end else if (s2_v_q) begin
            err_q <= err_q + (CNT_W+1)'(s2_err_q);
            sum_q <= sum_q + SUM_W'(s2_ed_q);
            if (s2_ed_q > max_q) max_q <= s2_ed_q;
         end
      end
   end

   assign s_if.in_ready  = in_ready_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign sample_count_o = cnt_q;
   assign err_count_o    = err_q;
   assign ed_sum_o       = sum_q;
   assign ed_max_o       = max_q;
endmodule

// File: tb/tb_approx_mul_err_accum.sv
// tb_approx_mul_err_accum: table of runs checked against a scoreboard of
// per-sample error distances, plus hand sequences for latency, ignored start and async reset.
module tb_approx_mul_err_accum;
   localparam int W = 8, CNT_W = 4, SUM_W = 2*W+CNT_W;

   typedef struct {
      int     n;
      int     mode;
      bit     gap;
      int     exp_cnt;
      int     exp_err;
      longint exp_sum;
      int     exp_max;
      int     exp_cyc;
   } run_t;

   logic             clk = 0, rst_n = 0, start = 0;
   logic [CNT_W-1:0] num = '0;
   logic             busy, done;
   logic [CNT_W:0]   scnt, ecnt;
   logic [SUM_W-1:0] esum;
   logic [2*W-1:0]   emax;
   int               total = 0, bad = 0, run_id = -1;
   int               q[$];
   run_t             runs[5];

   approx_mul_err_accum_if #(.W(W)) bus ();

   approx_mul_err_accum #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .num_samples_i(num), .s_if(bus),
      .busy_o(busy), .done_o(done), .sample_count_o(scnt), .err_count_o(ecnt),
      .ed_sum_o(esum), .ed_max_o(emax)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL run%0d %s: got %0d want %0d", run_id, name, act, exp);
      end
   endtask

   function automatic int ed_of(input logic [7:0] x, input logic [7:0] y, input logic [15:0] z);
      int p;
      p = int'(x) * int'(y);
      return (p >= int'(z)) ? p - int'(z) : int'(z) - p;
   endfunction

   task automatic gen(input int mode, input int i, output logic [7:0] x, output logic [7:0] y,
                      output logic [15:0] z);
      x = 8'(i*17 + 3);
      y = 8'(i*29 + 1);
      z = {8'h0, x} * {8'h0, y};
      if (mode == 1) z = z + 16'd5;
      else if (mode == 2) begin
         if (i % 3 == 0) begin x = 8'd255; y = 8'd255; z = 16'd0;  end
         if (i % 3 == 1) begin x = 8'd3;   y = 8'd4;   z = 16'd20; end
         if (i % 3 == 2) begin x = 8'd2;   y = 8'd2;   z = 16'd4;  end
      end else if (mode == 3) begin
         x = 8'($urandom);
         y = 8'($urandom);
         z = 16'($urandom);
      end
   endtask

   task automatic run_one(input run_t r);
      logic [7:0]  x, y;
      logic [15:0] z;
      int          acc = 0, cyc = 0, tgt, e, e_err = 0, e_max = 0, e_cnt;
      longint      e_sum = 0;
      bit          v, rdy;
      tgt = (r.n == 0) ? (1 << CNT_W) : r.n;
      q.delete();
      @(negedge clk);
      start = 1;
      num   = CNT_W'(r.n);
      @(posedge clk); #1;
      start = 0;
      chk("start_busy", busy, 1);
      chk("start_ready", bus.in_ready, 1);
      chk("start_done", done, 0);
      chk("start_sum_clr", esum, 0);
      chk("start_cnt_clr", scnt, 0);
      gen(r.mode, 0, x, y, z);
      while (!done && cyc < 200) begin
         @(negedge clk);
         v = !r.gap || (cyc % 2 == 0);
         bus.in_valid = v; bus.x = x; bus.y = y; bus.z = z;
         rdy = bus.in_ready;
         @(posedge clk); #1;
         cyc++;
         if (v && rdy) begin
            q.push_back(ed_of(x, y, z));
            acc++;
            gen(r.mode, acc, x, y, z);
            if (acc == tgt) chk("ready_drop", bus.in_ready, 0);
         end
         chk("busy_done_excl", busy & done, 0);
      end
      bus.in_valid = 0;
      if (!done) begin
         total++; bad++;
         $display("FAIL run%0d timeout: done=%0d after %0d cycles, want 1", run_id, done, cyc);
      end
      if (r.exp_cyc > 0) chk("run_cycles", cyc + 1, r.exp_cyc);
      e_cnt = q.size();
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e != 0) e_err++;
         e_sum += e;
         if (e > e_max) e_max = e;
      end
      chk("sample_count", scnt, e_cnt);
      chk("sample_count_tbl", scnt, r.exp_cnt);
      chk("err_count", ecnt, e_err);
      chk("ed_sum", esum, e_sum);
      chk("ed_max", emax, e_max);
      if (r.exp_err >= 0) begin
         chk("err_count_tbl", ecnt, r.exp_err);
         chk("ed_sum_tbl", esum, r.exp_sum);
         chk("ed_max_tbl", emax, r.exp_max);
      end
      @(negedge clk);
      bus.in_valid = 1;
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 0;
      chk("frozen_cnt", scnt, e_cnt);
      chk("frozen_sum", esum, e_sum);
      chk("frozen_done", done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      runs[0] = '{10, 0, 1'b0, 10, 0,  0,     0,     13};
      runs[1] = '{8,  1, 1'b0, 8,  8,  40,    5,     11};
      runs[2] = '{3,  2, 1'b0, 3,  2,  65033, 65025, 6};
      runs[3] = '{0,  3, 1'b1, 16, -1, 0,     0,     -1};
      runs[4] = '{5,  3, 1'b0, 5,  -1, 0,     0,     8};
      bus.in_valid = 0; bus.x = '0; bus.y = '0; bus.z = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_cnt", scnt, 0);
      chk("rst_err", ecnt, 0);
      chk("rst_sum", esum, 0);
      chk("rst_max", emax, 0);
      @(negedge clk);
      rst_n = 1;
      // latency, start ignored in RUN, then asynchronous abort
      @(negedge clk);
      start = 1; num = 4'd4;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      bus.in_valid = 1; bus.x = 8'd10; bus.y = 8'd10; bus.z = 16'd90;
      @(posedge clk); #1;
      chk("lat_k", esum, 0);
      @(negedge clk);
      bus.x = 8'd1; bus.y = 8'd1; bus.z = 16'd4;
      start = 1; num = 4'd1;
      @(posedge clk); #1;
      start = 0;
      chk("lat_k1", esum, 0);
      chk("ign_start_cnt", scnt, 2);
      chk("ign_start_busy", busy, 1);
      @(negedge clk);
      bus.in_valid = 0;
      @(posedge clk); #1;
      chk("lat_k2", esum, 10);
      chk("lat_k2_err", ecnt, 1);
      chk("ign_start_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      chk("lat_sum2", esum, 13);
      chk("lat_err2", ecnt, 2);
      chk("lat_max2", emax, 10);
      @(negedge clk); #2;
      rst_n = 0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_ready", bus.in_ready, 0);
      chk("abort_cnt", scnt, 0);
      chk("abort_err", ecnt, 0);
      chk("abort_sum", esum, 0);
      chk("abort_max", emax, 0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         run_id = i;
         run_one(runs[i]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
